// File: rtl/pll_drp_reconfig.sv
// DRP sequencer for PLLE2_ADV: holds the PLL in reset, read-modify-writes a table of
// registers through the DRP port, releases reset and waits for LOCKED.
module pll_drp_reconfig #(
  parameter int unsigned NUM_REGS     = 4,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     SSTEP,
  input  logic [7*NUM_REGS-1:0]    CFG_ADDR,
  input  logic [16*NUM_REGS-1:0]   CFG_MASK,
  input  logic [16*NUM_REGS-1:0]   CFG_DATA,
  output logic                     SRDY,
  output logic                     ERR,
  output logic [6:0]               DADDR,
  output logic                     DEN,
  output logic                     DWE,
  output logic [15:0]              DI,
  input  logic [15:0]              DO,
  input  logic                     DRDY,
  output logic                     PLL_RST,
  input  logic                     LOCKED
);

  localparam int unsigned IdxW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned DCntW = $clog2(DRDY_TIMEOUT) + 1;
  localparam int unsigned LCntW = $clog2(LOCK_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    StIdle, StRd, StWaitRd, StWr, StWaitWr, StNext, StWaitLock
  } state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [7*NUM_REGS-1:0]  addr_q, addr_d;
  logic [16*NUM_REGS-1:0] mask_q, mask_d;
  logic [16*NUM_REGS-1:0] data_q, data_d;
  logic                   srdy_q, srdy_d;
  logic                   err_q, err_d;
  logic [6:0]             daddr_q, daddr_d;
  logic                   den_q, den_d;
  logic                   dwe_q, dwe_d;
  logic [15:0]            di_q, di_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [DCntW-1:0]       dcnt_q, dcnt_d;
  logic [LCntW-1:0]       lcnt_q, lcnt_d;

  logic [6:0]  cur_addr;
  logic [15:0] cur_mask;
  logic [15:0] cur_data;
  logic        drp_timeout;

  assign cur_addr = addr_q[7*int'(idx_q) +: 7];
  assign cur_mask = mask_q[16*int'(idx_q) +: 16];
  assign cur_data = data_q[16*int'(idx_q) +: 16];

  // The wait window starts once the DEN pulse has dropped.
  assign drp_timeout = !den_q && (dcnt_q == DCntW'(DRDY_TIMEOUT - 1));

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      srdy_q    <= 1'b1;
      err_q     <= 1'b0;
      daddr_q   <= '0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      di_q      <= '0;
      pll_rst_q <= 1'b0;
      dcnt_q    <= '0;
      lcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      srdy_q    <= srdy_d;
      err_q     <= err_d;
      daddr_q   <= daddr_d;
      den_q     <= den_d;
      dwe_q     <= dwe_d;
      di_q      <= di_d;
      pll_rst_q <= pll_rst_d;
      dcnt_q    <= dcnt_d;
      lcnt_q    <= lcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    data_d    = data_q;
    srdy_d    = srdy_q;
    err_d     = err_q;
    daddr_d   = daddr_q;
    den_d     = 1'b0;
    dwe_d     = 1'b0;
    di_d      = di_q;
    pll_rst_d = pll_rst_q;
    dcnt_d    = dcnt_q;
    lcnt_d    = lcnt_q;

    unique case (state_q)
      StIdle: begin
        srdy_d = 1'b1;
        if (SSTEP) begin
          addr_d    = CFG_ADDR;
          mask_d    = CFG_MASK;
          data_d    = CFG_DATA;
          err_d     = 1'b0;
          idx_d     = '0;
          pll_rst_d = 1'b1;
          srdy_d    = 1'b0;
          state_d   = StRd;
        end
      end
      StRd: begin
        daddr_d = cur_addr;
        den_d   = 1'b1;
        dcnt_d  = '0;
        state_d = StWaitRd;
      end
      StWaitRd, StWaitWr: begin
        if (DRDY) begin
          if (state_q == StWaitRd) begin
            di_d    = (DO & cur_mask) | (cur_data & ~cur_mask);
            state_d = StWr;
          end else begin
            state_d = StNext;
          end
        end else if (drp_timeout) begin
          err_d     = 1'b1;
          pll_rst_d = 1'b0;
          srdy_d    = 1'b1;
          state_d   = StIdle;
        end else if (!den_q && (dcnt_q != {DCntW{1'b1}})) begin
          dcnt_d = dcnt_q + DCntW'(1);
        end
      end
      StWr: begin
        daddr_d = cur_addr;
        den_d   = 1'b1;
        dwe_d   = 1'b1;
        dcnt_d  = '0;
        state_d = StWaitWr;
      end
      StNext: begin
        if (idx_q == IdxW'(NUM_REGS - 1)) begin
          pll_rst_d = 1'b0;
          lcnt_d    = '0;
          state_d   = StWaitLock;
        end else begin
          idx_d   = idx_q + IdxW'(1);
          state_d = StRd;
        end
      end
      StWaitLock: begin
        if (LOCKED) begin
          err_d   = 1'b0;
          srdy_d  = 1'b1;
          state_d = StIdle;
        end else if (lcnt_q == LCntW'(LOCK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          srdy_d  = 1'b1;
          state_d = StIdle;
        end else if (lcnt_q != {LCntW{1'b1}}) begin
          lcnt_d = lcnt_q + LCntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign SRDY    = srdy_q;
  assign ERR     = err_q;
  assign DADDR   = daddr_q;
  assign DEN     = den_q;
  assign DWE     = dwe_q;
  assign DI      = di_q;
  assign PLL_RST = pll_rst_q;

endmodule
